board_drop_writer: RTL and testbench

//  Owns the Connect-4 board storage: ROWS x COLS cells of 2 bits (00 empty, 01 player1, 10 player2).
//  - Accepts "drop disc" requests (column, player) and scans that column one row per cycle, from bottom to top.
//  - Writes the disc into the lowest empty cell and reports the result.
//  - Exports the board as a flat vector; cell-state checkers and win detection read that vector.

---
 rtl/connect4_pkg.sv | 22 ++
 rtl/board_drop_writer_if.sv | 20 ++
 rtl/board_drop_writer.sv | 134 +++++++++++++
 tb/tb_board_drop_writer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: cell encodings, drop status codes and default board size.
package connect4_pkg;

  localparam int ROWS_DEF = 6;
  localparam int COLS_DEF = 7;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  typedef enum logic [1:0] {
    ST_OK         = 2'b00,
    ST_COL_FULL   = 2'b01,
    ST_BAD_COL    = 2'b10,
    ST_BAD_PLAYER = 2'b11
  } status_t;

  function automatic logic is_player(input logic [1:0] code);
    return (code == CELL_P1) || (code == CELL_P2);
  endfunction

endpackage

// File: rtl/board_drop_writer_if.sv
// Drop request / result handshake between a game controller and the board writer.
interface board_drop_writer_if;
  logic       drop_valid_i;
  logic       drop_ready_o;
  logic [2:0] drop_col_i;
  logic [1:0] drop_player_i;
  logic       done_o;
  logic [1:0] status_o;
  logic [2:0] row_o;

  modport master (
    output drop_valid_i, drop_col_i, drop_player_i,
    input  drop_ready_o, done_o, status_o, row_o
  );

  modport slave (
    input  drop_valid_i, drop_col_i, drop_player_i,
    output drop_ready_o, done_o, status_o, row_o
  );
endinterface

// File: rtl/board_drop_writer.sv
// Connect-4 board storage: scans a column bottom-up one row per cycle and drops a disc
// into the lowest empty cell, exporting the flat board, move count and full flag.
module board_drop_writer
  import connect4_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear_i,
  board_drop_writer_if.slave       drop,
  output logic [2*ROWS*COLS-1:0]   board_o,
  output logic [5:0]               moves_o,
  output logic                     board_full_o
);

  localparam int         CELLS     = ROWS * COLS;
  localparam int         IDX_W     = $clog2(CELLS);
  localparam logic [5:0] MAX_MOVES = 6'(CELLS);
  localparam logic [3:0] COLS_L    = 4'(COLS);
  localparam logic [2:0] ROW_BOT   = 3'(ROWS - 1);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t         state, state_nxt;
  logic [1:0]     cells [CELLS];
  logic [2:0]     col_q, row_q, row_nxt;
  logic [1:0]     player_q;
  logic [5:0]     moves_q;
  logic           done_q, done_nxt;
  status_t        status_q, status_nxt;
  logic [2:0]     row_out_q, row_out_nxt;
  logic           load, wr_en;
  logic [IDX_W-1:0] cell_idx;

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == MAX_MOVES) ? v : v + 6'd1;
  endfunction

  assign cell_idx = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);

  assign drop.drop_ready_o = (state == S_IDLE) && !clear_i;
  assign drop.done_o       = done_q;
  assign drop.status_o     = status_q;
  assign drop.row_o        = row_out_q;
  assign moves_o           = moves_q;

  always_comb begin
    state_nxt   = state;
    row_nxt     = row_q;
    done_nxt    = 1'b0;
    status_nxt  = status_q;
    row_out_nxt = row_out_q;
    load        = 1'b0;
    wr_en       = 1'b0;
    if (!clear_i) begin
      case (state)
        S_IDLE: begin
          if (drop.drop_valid_i) begin
            load    = 1'b1;
            row_nxt = ROW_BOT;
            if ({1'b0, drop.drop_col_i} >= COLS_L) begin
              done_nxt   = 1'b1;
              status_nxt = ST_BAD_COL;
            end else if (!is_player(drop.drop_player_i)) begin
              done_nxt   = 1'b1;
              status_nxt = ST_BAD_PLAYER;
            end else begin
              state_nxt = S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (cells[cell_idx] == CELL_EMPTY) begin
            wr_en       = 1'b1;
            done_nxt    = 1'b1;
            status_nxt  = ST_OK;
            row_out_nxt = row_q;
            state_nxt   = S_IDLE;
          end else if (row_q != 3'd0) begin
            row_nxt = row_q - 3'd1;
          end else begin
            done_nxt   = 1'b1;
            status_nxt = ST_COL_FULL;
            state_nxt  = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      player_q  <= '0;
      moves_q   <= '0;
      done_q    <= 1'b0;
      status_q  <= ST_OK;
      row_out_q <= '0;
      for (int i = 0; i < CELLS; i++) cells[i] <= CELL_EMPTY;
    end else begin
      state     <= clear_i ? S_IDLE : state_nxt;
      row_q     <= row_nxt;
      done_q    <= done_nxt;
      status_q  <= status_nxt;
      row_out_q <= row_out_nxt;
      if (load) begin
        col_q    <= drop.drop_col_i;
        player_q <= drop.drop_player_i;
      end
      // clear wins over an in-flight write; only empty cells are ever targeted
      if (clear_i) begin
        moves_q <= '0;
        for (int i = 0; i < CELLS; i++) cells[i] <= CELL_EMPTY;
      end else if (wr_en) begin
        moves_q         <= sat_inc(moves_q);
        cells[cell_idx] <= player_q;
      end
    end
  end

  always_comb begin
    board_o      = '0;
    board_full_o = 1'b1;
    for (int i = 0; i < CELLS; i++) board_o[2*i +: 2] = cells[i];
    for (int c = 0; c < COLS; c++)
      if (cells[c] == CELL_EMPTY) board_full_o = 1'b0;
  end

endmodule

// File: tb/tb_board_drop_writer.sv
// Directed bench for board_drop_writer with a reference board model and a result scoreboard.
module tb_board_drop_writer;
  import connect4_pkg::*;

  localparam int ROWS  = 6;
  localparam int COLS  = 7;
  localparam int CELLS = ROWS * COLS;

  typedef struct {
    logic [1:0] st;
    logic [2:0] row;
    int         lat;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   clear_i = 1'b0;
  logic [2*CELLS-1:0]     board_o;
  logic [5:0]             moves_o;
  logic                   board_full_o;

  board_drop_writer_if dif ();

  board_drop_writer #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (clear_i),
    .drop         (dif),
    .board_o      (board_o),
    .moves_o      (moves_o),
    .board_full_o (board_full_o)
  );

  always #5 clk = ~clk;

  int         vecs = 0;
  int         errs = 0;
  exp_t       sb[$];
  logic [1:0] mb [ROWS][COLS];
  int         mmoves = 0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mb[r][c] = 2'b00;
    mmoves = 0;
  endtask

  function automatic logic [2*CELLS-1:0] model_board();
    logic [2*CELLS-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) v[2*(r*COLS+c) +: 2] = mb[r][c];
    return v;
  endfunction

  function automatic logic model_full();
    logic f;
    f = 1'b1;
    for (int c = 0; c < COLS; c++) if (mb[0][c] == 2'b00) f = 1'b0;
    return f;
  endfunction

  // Called at a negedge; leaves the bench at the negedge where done_o was seen.
  task automatic do_drop(input logic [2:0] col, input logic [1:0] pl);
    exp_t e;
    exp_t g;
    int   cnt;
    bit   got;
    int   found;
    if (col >= 3'(COLS)) begin
      e.st = 2'b10; e.row = 3'd0; e.lat = 1;
    end else if (pl == 2'b00 || pl == 2'b11) begin
      e.st = 2'b11; e.row = 3'd0; e.lat = 1;
    end else begin
      found = -1;
      for (int r = ROWS - 1; r >= 0; r--)
        if (found < 0 && mb[r][col] == 2'b00) found = r;
      if (found >= 0) begin
        mb[found][col] = pl;
        if (mmoves < CELLS) mmoves++;
        e.st = 2'b00; e.row = 3'(found); e.lat = (ROWS - 1 - found) + 2;
      end else begin
        e.st = 2'b01; e.row = 3'd0; e.lat = ROWS + 1;
      end
    end
    sb.push_back(e);
    dif.drop_valid_i  = 1'b1;
    dif.drop_col_i    = col;
    dif.drop_player_i = pl;
    check("ready_before_drop", 96'(dif.drop_ready_o), 96'(1));
    @(posedge clk);
    #1 dif.drop_valid_i = 1'b0;
    cnt = 0;
    got = 1'b0;
    while (cnt < 20 && !got) begin
      @(negedge clk);
      cnt++;
      if (dif.done_o) got = 1'b1;
    end
    check("done_seen", 96'(got), 96'(1));
    g = sb.pop_front();
    if (got) begin
      check("status", 96'(dif.status_o), 96'(g.st));
      if (g.st == 2'b00) check("row", 96'(dif.row_o), 96'(g.row));
      check("latency", 96'(cnt), 96'(g.lat));
      check("board", 96'(board_o), 96'(model_board()));
      check("moves", 96'(moves_o), 96'(mmoves));
      check("board_full", 96'(board_full_o), 96'(model_full()));
    end
  endtask

  // Accept a drop without scoreboarding it; returns at the negedge of the first SCAN cycle.
  task automatic start_raw(input logic [2:0] col, input logic [1:0] pl);
    dif.drop_valid_i  = 1'b1;
    dif.drop_col_i    = col;
    dif.drop_player_i = pl;
    @(posedge clk);
    #1 dif.drop_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(posedge clk);
    #1 clear_i = 1'b0;
    model_clear();
    @(negedge clk);
    check("clear_board", 96'(board_o), 96'(0));
    check("clear_moves", 96'(moves_o), 96'(0));
    check("clear_full", 96'(board_full_o), 96'(0));
  endtask

  task automatic watch_no_done(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (dif.done_o) seen = 1'b1;
    end
    check(tag, 96'(seen), 96'(0));
  endtask

  initial begin
    dif.drop_valid_i  = 1'b0;
    dif.drop_col_i    = 3'd0;
    dif.drop_player_i = 2'b00;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check("rst_done", 96'(dif.done_o), 96'(0));
    check("rst_status", 96'(dif.status_o), 96'(0));
    check("rst_row", 96'(dif.row_o), 96'(0));
    check("rst_moves", 96'(moves_o), 96'(0));
    check("rst_ready", 96'(dif.drop_ready_o), 96'(1));
    check("rst_board", 96'(board_o), 96'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // reset in the middle of a scan
    do_drop(3'd6, 2'b01);
    do_drop(3'd6, 2'b10);
    start_raw(3'd6, 2'b01);
    reset_n = 1'b0;
    @(negedge clk);
    model_clear();
    check("midrst_board", 96'(board_o), 96'(0));
    check("midrst_moves", 96'(moves_o), 96'(0));
    check("midrst_ready", 96'(dif.drop_ready_o), 96'(1));
    check("midrst_done", 96'(dif.done_o), 96'(0));
    reset_n = 1'b1;
    watch_no_done("midrst_no_done", 10);

    // single drop on an empty board
    do_drop(3'd3, 2'b01);
    check("c3_cell", 96'(board_o[2*(5*COLS+3) +: 2]), 96'(1));
    do_clear();

    // fill column 0, then overflow it
    for (int k = 0; k < ROWS; k++) do_drop(3'd0, (k % 2 == 0) ? 2'b01 : 2'b10);
    do_drop(3'd0, 2'b01);

    // bad requests
    do_drop(3'd7, 2'b01);
    @(negedge clk);
    check("done_one_cycle", 96'(dif.done_o), 96'(0));
    do_drop(3'd2, 2'b11);
    do_drop(3'd7, 2'b00);
    do_drop(3'd2, 2'b00);
    do_clear();

    // clear while scanning a column holding three discs, with a competing request
    for (int k = 0; k < 3; k++) do_drop(3'd4, 2'b10);
    start_raw(3'd4, 2'b01);
    clear_i = 1'b1;
    dif.drop_valid_i  = 1'b1;
    dif.drop_col_i    = 3'd1;
    dif.drop_player_i = 2'b01;
    check("ready_during_clear", 96'(dif.drop_ready_o), 96'(0));
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    dif.drop_valid_i = 1'b0;
    model_clear();
    watch_no_done("abort_no_done", 10);
    check("abort_board", 96'(board_o), 96'(0));
    check("abort_moves", 96'(moves_o), 96'(0));
    check("abort_ready", 96'(dif.drop_ready_o), 96'(1));

    // fill the whole board
    for (int c = 0; c < COLS; c++)
      for (int k = 0; k < ROWS; k++)
        do_drop(3'(c), ((c + k) % 2 == 0) ? 2'b01 : 2'b10);
    check("full_flag", 96'(board_full_o), 96'(1));
    check("full_moves", 96'(moves_o), 96'(CELLS));
    do_drop(3'd3, 2'b10);
    do_clear();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
